// File: rtl/uart_pkg.sv
// Shared UART transmit types: serializer state encoding and parity mode codes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Bit that makes the total count of ones odd or even, depending on mode.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic BitTick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clock) begin
    if (!Reset || Clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign BitTick = (count == LAST) && !Clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
//   state  | meaning
//   IDLE   | TxEmpty high, waiting for XMitGo
//   START  | driving the start bit (0)
//   DATA   | shifting data bits out, LSB first
//   PARITY | driving the parity bit (only when PARITY != 0)
//   STOP   | driving STOP_BITS stop bits (1)
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       XMitGo,
  input  logic [7:0] TxData,
  output logic       TxEmpty,
  output logic       TxD,
  output logic       TxDone
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic STOP_LAST  = (STOP_BITS == 2);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
      $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
  endgenerate

  tx_state_t  state;
  logic [7:0] shifter;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       par_bit;
  logic       bit_tick;
  logic       baud_clear;

  // Holding the timer cleared while idle restarts the bit period on the accept edge.
  assign baud_clear = (state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .Clock  (Clock),
    .Reset  (Reset),
    .Clear  (baud_clear),
    .BitTick(bit_tick)
  );

  // The PARITY parameter shadows the imported state name, so the state is package-qualified.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      TxD      <= 1'b1;
      TxEmpty  <= 1'b1;
      TxDone   <= 1'b0;
      shifter  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      case (state)
        IDLE: begin
          if (XMitGo) begin
            shifter  <= TxData;
            par_bit  <= parity_bit(TxData, PARITY);
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            TxEmpty  <= 1'b0;
            TxD      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            TxD     <= shifter[0];
            shifter <= {1'b0, shifter[7:1]};
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == 3'd7) begin
              if (PARITY != PARITY_NONE) begin
                TxD   <= par_bit;
                state <= uart_pkg::PARITY;
              end else begin
                TxD   <= 1'b1;
                state <= STOP;
              end
            end else begin
              TxD     <= shifter[0];
              shifter <= {1'b0, shifter[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (bit_tick) begin
            TxD   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (stop_idx == STOP_LAST) begin
              TxEmpty <= 1'b1;
              TxDone  <= 1'b1;
              state   <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three parameterisations share one stimulus stream and are
// checked every cycle against a frame-bit-array model; a line receiver decodes instance 0.
module tb_uart_tx_serializer;

  localparam int CPB = 10;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       XMitGo = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic [2:0] txd_v, empty_v, done_v;

  always #5 Clock = ~Clock;

  uart_tx_serializer #(.CLK_FREQ(50), .BAUD(5), .PARITY(0), .STOP_BITS(1)) dut0 (
    .Clock(Clock), .Reset(Reset), .XMitGo(XMitGo), .TxData(TxData),
    .TxEmpty(empty_v[0]), .TxD(txd_v[0]), .TxDone(done_v[0]));
  uart_tx_serializer #(.CLK_FREQ(50), .BAUD(5), .PARITY(2), .STOP_BITS(2)) dut1 (
    .Clock(Clock), .Reset(Reset), .XMitGo(XMitGo), .TxData(TxData),
    .TxEmpty(empty_v[1]), .TxD(txd_v[1]), .TxDone(done_v[1]));
  uart_tx_serializer #(.CLK_FREQ(50), .BAUD(5), .PARITY(1), .STOP_BITS(1)) dut2 (
    .Clock(Clock), .Reset(Reset), .XMitGo(XMitGo), .TxData(TxData),
    .TxEmpty(empty_v[2]), .TxD(txd_v[2]), .TxDone(done_v[2]));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int par_of(input int i);
    case (i)
      1: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Model: each accepted frame is a list of line bits; elapsed time picks the bit.
  logic m_bits [3][0:11];
  int   m_busy [3];
  int   m_t    [3];
  int   m_len  [3];
  logic m_txd  [3];
  logic m_empty[3];
  logic m_done [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_t[i] = 0; m_len[i] = 0;
      m_txd[i] = 1'b1; m_empty[i] = 1'b1; m_done[i] = 1'b0;
    end
  end

  always @(posedge Clock) begin
    int n;
    for (int i = 0; i < 3; i++) begin
      if (Reset !== 1'b1) begin
        m_busy[i] = 0; m_txd[i] = 1'b1; m_empty[i] = 1'b1; m_done[i] = 1'b0;
      end else if (m_busy[i] == 0) begin
        m_done[i] = 1'b0;
        if (XMitGo === 1'b1) begin
          n = 0;
          m_bits[i][n] = 1'b0; n++;
          for (int b = 0; b < 8; b++) begin
            m_bits[i][n] = TxData[b]; n++;
          end
          if (par_of(i) == 2) begin
            m_bits[i][n] = ^TxData; n++;
          end else if (par_of(i) == 1) begin
            m_bits[i][n] = ~^TxData; n++;
          end
          for (int s = 0; s < stop_of(i); s++) begin
            m_bits[i][n] = 1'b1; n++;
          end
          m_len[i]   = n * CPB;
          m_t[i]     = 0;
          m_busy[i]  = 1;
          m_txd[i]   = m_bits[i][0];
          m_empty[i] = 1'b0;
        end
      end else begin
        m_t[i]++;
        m_done[i] = 1'b0;
        if (m_t[i] == m_len[i]) begin
          m_busy[i] = 0; m_empty[i] = 1'b1; m_done[i] = 1'b1; m_txd[i] = 1'b1;
        end else begin
          m_txd[i] = m_bits[i][m_t[i] / CPB];
        end
      end
    end
  end

  // Receiver for instance 0 (no parity, one stop bit), sampling mid-bit.
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];
  int         frame_err = 0;

  always begin
    @(posedge Clock);
    #1;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("txd[%0d]", i), {31'd0, txd_v[i]}, {31'd0, m_txd[i]});
        chk($sformatf("txempty[%0d]", i), {31'd0, empty_v[i]}, {31'd0, m_empty[i]});
        chk($sformatf("txdone[%0d]", i), {31'd0, done_v[i]}, {31'd0, m_done[i]});
      end
      if (Reset !== 1'b1) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (txd_v[0] === 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == 5 && txd_v[0] !== 1'b0) begin
          frame_err++;
          rx_busy = 1'b0;
        end else if (rx_cnt >= 15 && rx_cnt <= 85 && (rx_cnt - 5) % 10 == 0) begin
          rx_byte[(rx_cnt - 15) / 10] = txd_v[0];
        end else if (rx_cnt == 95) begin
          if (txd_v[0] !== 1'b1) frame_err++;
          else rx_q.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  end

  int          low [3];
  int          dn  [3];
  logic [11:0] samp[3];

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // One-cycle request, then 130 cycles of per-instance measurement starting at t=0.
  task automatic run_frame(input logic [7:0] d);
    XMitGo = 1'b1;
    TxData = d;
    @(negedge Clock);
    XMitGo = 1'b0;
    TxData = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      low[i] = 0; dn[i] = 0; samp[i] = '0;
    end
    for (int c = 0; c < 130; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (empty_v[i] === 1'b0) low[i]++;
        if (done_v[i] === 1'b1) dn[i]++;
        if (c % 10 == 5 && c / 10 < 12) samp[i][c / 10] = txd_v[i];
      end
      @(negedge Clock);
    end
  endtask

  task automatic wait_empty0(input logic lvl, input int lim, input string nm);
    int w = 0;
    while (empty_v[0] !== lvl && w < lim) begin
      @(negedge Clock);
      w++;
    end
    chk(nm, {31'd0, (empty_v[0] === lvl)}, 32'd1);
  endtask

  initial begin
    string msg = "Hello World!\n";
    int    err0;
    int    dcount;
    int    hold;

    // Reset and idle
    Reset = 1'b0;
    tick(2);
    Reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_txd", {31'd0, txd_v[0]}, 32'd1);
    chk("rst_empty", {29'd0, empty_v}, 32'd7);
    chk("rst_done", {29'd0, done_v}, 32'd0);
    tick(50);
    chk("idle_txd", {29'd0, txd_v}, 32'd7);
    chk("idle_empty", {29'd0, empty_v}, 32'd7);

    // Single frame 0x48
    rx_q.delete();
    run_frame(8'h48);
    chk("h48_bits", {22'd0, samp[0][9:0]}, 32'b1010010000);
    chk("h48_low0", low[0], 100);
    chk("h48_done0", dn[0], 1);
    chk("h48_low1", low[1], 120);
    chk("h48_low2", low[2], 110);
    chk("h48_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("h48_rx", {24'd0, rx_q[0]}, 32'h48);

    // Parity bits for 0x07
    run_frame(8'h07);
    chk("even_par", {31'd0, samp[1][9]}, 32'd1);
    chk("odd_par", {31'd0, samp[2][9]}, 32'd0);
    chk("stop2_a", {31'd0, samp[1][10]}, 32'd1);
    chk("stop2_b", {31'd0, samp[1][11]}, 32'd1);
    chk("stop2_low", low[1], 120);

    // XMitGo held, data changed mid-frame, back-to-back second frame
    rx_q.delete();
    XMitGo = 1'b1;
    TxData = 8'hC3;
    @(negedge Clock);
    tick(30);
    TxData = 8'h3C;
    wait_empty0(1'b1, 200, "b2b_wait_idle");
    @(negedge Clock);
    chk("b2b_gap", {31'd0, empty_v[0]}, 32'd0);
    XMitGo = 1'b0;
    tick(150);
    chk("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", {24'd0, rx_q[0]}, 32'hC3);
      chk("b2b_rx1", {24'd0, rx_q[1]}, 32'h3C);
    end

    // Reset during data bit 4
    rx_q.delete();
    XMitGo = 1'b1;
    TxData = 8'h5A;
    @(negedge Clock);
    XMitGo = 1'b0;
    tick(55);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    chk("abort_txd", {29'd0, txd_v}, 32'd7);
    chk("abort_empty", {29'd0, empty_v}, 32'd7);
    chk("abort_done", {29'd0, done_v}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 150; c++) begin
      if (done_v !== 3'b000) dcount++;
      @(negedge Clock);
    end
    chk("abort_no_done", dcount, 0);
    run_frame(8'h21);
    chk("h21_bits", {22'd0, samp[0][9:0]}, 32'b1001000010);
    chk("h21_done0", dn[0], 1);
    chk("h21_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("h21_rx", {24'd0, rx_q[0]}, 32'h21);

    // Driver loop streaming the message twice
    rx_q.delete();
    err0 = frame_err;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < msg.len(); k++) begin
        wait_empty0(1'b1, 300, "drv_wait_idle");
        XMitGo = 1'b1;
        TxData = msg[k];
        @(negedge Clock);
        wait_empty0(1'b0, 5, "drv_wait_busy");
        XMitGo = 1'b0;
      end
    end
    tick(150);
    chk("msg_rx_count", rx_q.size(), 2 * msg.len());
    for (int j = 0; j < rx_q.size() && j < 2 * msg.len(); j++) begin
      chk($sformatf("msg_rx[%0d]", j), {24'd0, rx_q[j]}, {24'd0, msg[j % msg.len()]});
    end
    chk("msg_frame_err", frame_err - err0, 0);

    // Randomized requests, hold times, data churn and occasional resets
    for (int n = 0; n < 40; n++) begin
      XMitGo = 1'b1;
      TxData = 8'($urandom);
      hold = $urandom_range(1, 140);
      for (int c = 0; c < hold; c++) begin
        @(negedge Clock);
        if ($urandom_range(0, 3) == 0) TxData = 8'($urandom);
        Reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      end
      Reset = 1'b1;
      XMitGo = 1'b0;
      tick($urandom_range(0, 60));
    end
    tick(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
